instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the instruction-memory word-address width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL begin a load session when the block is IDLE.
REQ-005 base_addr  input  ADDR_W  SHALL be the first word address; sampled on the accepted start.
REQ-006 in_valid  input  1  SHALL flag that the instruction fields are valid.
REQ-007 in_ready  output  1  SHALL flag that the block accepts fields this cycle.
REQ-008 in_last  input  1  SHALL mark the final instruction of the session.
REQ-009 opcode, functcode  input  6 each  SHALL be the MIPS opcode and funct fields.
REQ-010 rs, rt, rd, shamt  input  5 each  SHALL be the register and shift fields.
REQ-011 imm  input  16  SHALL be the I-type immediate.
REQ-012 target  input  26  SHALL be the J-type target.
REQ-013 im_we  output  1  SHALL be the instruction-memory write strobe.
REQ-014 im_addr  output  ADDR_W  SHALL be the write word address.
REQ-015 im_wdata  output  32  SHALL be the encoded instruction word.
REQ-016 done  output  1  SHALL pulse for one cycle at session end.
REQ-017 error  output  1  SHALL be a sticky flag for unsupported encodings.
REQ-018 overflow  output  1  SHALL be a sticky flag for address exhaustion.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, LOAD, WRITE and DONE.
REQ-020 IDLE SHALL move to LOAD on start, load the address counter from base_addr, and clear error and overflow.
REQ-021 in_ready SHALL be 1 only in LOAD; a transfer SHALL occur when in_valid and in_ready are both 1.
REQ-022 Supported opcodes SHALL be RTYPE 0x00, LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0e, J 0x02 and JAL 0x03.
REQ-023 Supported RTYPE funct codes SHALL be JR 0x08, ADD 0x20, SUB 0x22 and SLT 0x2a.
REQ-024 R-type words SHALL be encoded as {opcode, rs, rt, rd, shamt, functcode}; for JR, rt, rd and shamt SHALL be forced to 0.
REQ-025 I-type words (LW, SW, BEQ, BNE, ADDI, XORI) SHALL be encoded as {opcode, rs, rt, imm}.
REQ-026 J-type words (J, JAL) SHALL be encoded as {opcode, target}.
REQ-027 A transfer with a supported encoding SHALL register the encoded word and move to WRITE.
REQ-028 In WRITE, im_we SHALL be 1 for exactly one cycle, with im_addr and im_wdata stable; write latency SHALL be 1 cycle after the transfer.
REQ-029 After WRITE, the address counter SHALL increment by 1.
- Next state SHALL be DONE if in_last was set on the transfer, else LOAD.
REQ-030 An unsupported opcode or funct SHALL set error, perform no write, and leave the address unchanged.
- Next state SHALL be DONE if in_last was set, else stay in LOAD.
REQ-031 If the written address equals 2^ADDR_W-1 and in_last was not set, overflow SHALL be set and the FSM SHALL go to DONE; there SHALL be no wrap-around.
REQ-032 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-033 start SHALL be ignored outside IDLE.
REQ-034 im_we SHALL be 0 in every state other than WRITE.

Reset
REQ-035 reset SHALL force the state to IDLE, and im_we, in_ready, done, error and overflow to 0.
REQ-036 reset SHALL force im_addr and im_wdata to 0.
REQ-037 reset asserted mid-session, including during WRITE, SHALL abort the session; im_we SHALL be 0 in the next cycle.

Structure
REQ-038 Opcode, funct and state encodings SHALL live in a shared package shared with the decoder.
REQ-039 Encoding SHALL be a combinational sub-module, instr_pack, that outputs the word plus a supported flag.
- The FSM, address counter and flags SHALL live in instruction_encoder.

Verification
REQ-040 ADD rs=1 rt=2 rd=3 shamt=0, base 0x010 -> one im_we cycle, addr 0x010, data 0x00221820.
REQ-041 LW rs=29 rt=8 imm=0x0004, then JAL target=0x0000010 with in_last=1 -> data 0x8FA80004 then 0x0C000010 at consecutive addresses, then a done pulse.
REQ-042 Opcode 0x0f with in_last=0, followed by a valid SW -> no write for the first, error=1, SW written at the unchanged address.
REQ-043 ADDR_W=2, base 0, five valid instructions -> four writes to addresses 0..3, overflow=1, done, fifth not accepted.
REQ-044 reset asserted in the WRITE cycle -> im_we=0 next cycle, state IDLE, all flags 0.
REQ-045 in_valid held 0 for 5 cycles in LOAD, then JR rs=31 rt=7 -> in_ready held 1 throughout, data 0x03E00008.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared MIPS encoding constants for the instruction encoder and decoder.
// Holds the opcode/funct values, the loader FSM state type, and a classifier
// that maps an (opcode, funct) pair onto its word format.
package instruction_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } instr_fmt_e;

  function automatic instr_fmt_e classify(input logic [5:0] opcode,
                                          input logic [5:0] functcode);
    instr_fmt_e fmt;
    fmt = FMT_BAD;
    case (opcode)
      OP_RTYPE: begin
        if (functcode == FN_JR  || functcode == FN_ADD ||
            functcode == FN_SUB || functcode == FN_SLT) begin
          fmt = FMT_R;
        end
      end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI: fmt = FMT_I;
      OP_J, OP_JAL:                                   fmt = FMT_J;
      default:                                        fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// instr_pack: combinational MIPS word packer.
// Inputs : opcode, functcode, rs, rt, rd, shamt, imm, target (raw fields)
// Outputs: word      - encoded 32-bit instruction (0 when unsupported)
//          supported - 1 when opcode/funct form a supported encoding
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  functcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        supported
);

  always_comb begin
    word      = '0;
    supported = 1'b0;
    case (classify(opcode, functcode))
      FMT_R: begin
        supported = 1'b1;
        // JR only carries rs; the other register/shift fields are zeroed.
        if (functcode == FN_JR) begin
          word = {opcode, rs, 5'd0, 5'd0, 5'd0, functcode};
        end else begin
          word = {opcode, rs, rt, rd, shamt, functcode};
        end
      end
      FMT_I: begin
        supported = 1'b1;
        word      = {opcode, rs, rt, imm};
      end
      FMT_J: begin
        supported = 1'b1;
        word      = {opcode, target};
      end
      default: begin
        supported = 1'b0;
        word      = '0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: loads a session of MIPS instructions into instruction
// memory, one encoded word per accepted field set.
// Ports:
//   clk, reset (sync, active-high)
//   start, base_addr          - begin a session at base_addr (IDLE only)
//   in_valid/in_ready/in_last - field handshake; in_last ends the session
//   opcode..target            - raw instruction fields
//   im_we, im_addr, im_wdata  - single-cycle instruction-memory write
//   done                      - one-cycle end-of-session pulse
//   error, overflow           - sticky flags, cleared on the next start
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        opcode,
  input  logic [5:0]        functcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              done,
  output logic              error,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              error_q, error_d;
  logic              overflow_q, overflow_d;

  logic [31:0]       pack_word;
  logic              pack_ok;

  instr_pack u_pack (
    .opcode    (opcode),
    .functcode (functcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm       (imm),
    .target    (target),
    .word      (pack_word),
    .supported (pack_ok)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    error_d    = error_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          addr_d     = base_addr;
          error_d    = 1'b0;
          overflow_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (pack_ok) begin
            wdata_d = pack_word;
            last_d  = in_last;
            state_d = ST_WRITE;
          end else begin
            // Rejected encodings consume the transfer but leave the address alone.
            error_d = 1'b1;
            if (in_last) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_WRITE: begin
        // The counter saturates at the top word; there is no wrap-around.
        if (addr_q != ADDR_MAX) begin
          addr_d = addr_q + ADDR_W'(1);
        end
        if (last_q) begin
          state_d = ST_DONE;
        end else if (addr_q == ADDR_MAX) begin
          overflow_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign im_we    = (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign error    = error_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Testbench for instruction_encoder: vector table, directed multi-cycle
// sequences, randomized sessions against a reference model, and a narrow
// ADDR_W=2 instance for address exhaustion.
module tb_instruction_encoder;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [25:0] tg;
    logic        ok;
    logic [31:0] w;
  } vec_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [5:0]  opcode;
  logic [5:0]  functcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        done;
  logic        error;
  logic        overflow;

  logic        s_start;
  logic [1:0]  s_base;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_done;
  logic        s_err;
  logic        s_ovf;

  int checks   = 0;
  int failures = 0;

  wr_t        exp_q[$];
  logic [9:0] m_addr;
  logic       m_err;
  logic       m_ovf;
  logic       sess_end;
  logic       prev_we;

  vec_t tbl[12];

  instruction_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .functcode(functcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm), .target(target),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .done(done), .error(error), .overflow(overflow)
  );

  instruction_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .base_addr(s_base),
    .in_valid(s_valid), .in_ready(s_ready), .in_last(s_last),
    .opcode(opcode), .functcode(functcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm), .target(target),
    .im_we(s_we), .im_addr(s_addr), .im_wdata(s_wdata),
    .done(s_done), .error(s_err), .overflow(s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference encoder written from the field-layout rules.
  function automatic vec_t ref_encode(input vec_t v);
    vec_t r;
    r = v;
    r.ok = 1'b0;
    r.w  = 32'h0;
    if (v.op == 6'h00) begin
      if (v.fn == 6'h08 || v.fn == 6'h20 || v.fn == 6'h22 || v.fn == 6'h2a) begin
        r.ok = 1'b1;
        if (v.fn == 6'h08) r.w = (32'(v.rs) << 21) | 32'(v.fn);
        else r.w = (32'(v.rs) << 21) | (32'(v.rt) << 16) | (32'(v.rd) << 11) |
                   (32'(v.sh) << 6) | 32'(v.fn);
      end
    end else if (v.op == 6'h23 || v.op == 6'h2b || v.op == 6'h04 ||
                 v.op == 6'h05 || v.op == 6'h08 || v.op == 6'h0e) begin
      r.ok = 1'b1;
      r.w  = (32'(v.op) << 26) | (32'(v.rs) << 21) | (32'(v.rt) << 16) | 32'(v.imm);
    end else if (v.op == 6'h02 || v.op == 6'h03) begin
      r.ok = 1'b1;
      r.w  = (32'(v.op) << 26) | 32'(v.tg);
    end
    return r;
  endfunction

  function automatic vec_t rand_instr();
    vec_t v;
    logic [5:0] ops [13];
    logic [5:0] fns [6];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0e, 6'h02, 6'h03,
            6'h0f, 6'h01, 6'h3f, 6'h21};
    fns = '{6'h08, 6'h20, 6'h22, 6'h2a, 6'h21, 6'h00};
    v.op  = ops[$urandom_range(0, 12)];
    v.fn  = fns[$urandom_range(0, 5)];
    v.rs  = 5'($urandom);
    v.rt  = 5'($urandom);
    v.rd  = 5'($urandom);
    v.sh  = 5'($urandom);
    v.imm = 16'($urandom);
    v.tg  = 26'($urandom);
    v.ok  = 1'b0;
    v.w   = 32'h0;
    return ref_encode(v);
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] c, input logic [4:0] sh,
                              input logic [15:0] im, input logic [25:0] tg,
                              input logic ok, input logic [31:0] w);
    vec_t v;
    v.op = op; v.fn = fn; v.rs = a; v.rt = b; v.rd = c; v.sh = sh;
    v.imm = im; v.tg = tg; v.ok = ok; v.w = w;
    return v;
  endfunction

  // Write monitor: every im_we cycle must match the next expected write.
  always @(negedge clk) begin
    if (im_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %h data %h required=no write", im_addr, im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(im_addr), 32'(e.a));
        chk("wr_data", im_wdata, e.d);
      end
      if (prev_we) begin
        checks++;
        failures++;
        $display("FAIL we_pulse actual=2 consecutive cycles required=1 cycle");
      end
    end
    prev_we <= im_we;
  end

  task automatic set_fields(input vec_t v);
    opcode = v.op; functcode = v.fn; rs = v.rs; rt = v.rt; rd = v.rd;
    shamt = v.sh; imm = v.imm; target = v.tg;
  endtask

  task automatic start_session(input logic [9:0] b);
    base_addr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_addr = b;
    m_err = 1'b0;
    m_ovf = 1'b0;
    sess_end = 1'b0;
  endtask

  task automatic xfer(input vec_t v, input logic last);
    int n;
    wr_t e;
    set_fields(v);
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout actual=in_ready 0 required=in_ready 1");
      in_valid = 1'b0;
      in_last = 1'b0;
      sess_end = 1'b1;
      return;
    end
    if (v.ok) begin
      e.a = m_addr;
      e.d = v.w;
      exp_q.push_back(e);
      if (last) sess_end = 1'b1;
      else if (m_addr == 10'h3FF) begin
        m_ovf = 1'b1;
        sess_end = 1'b1;
      end
      if (m_addr != 10'h3FF) m_addr = m_addr + 10'd1;
    end else begin
      m_err = 1'b1;
      if (last) sess_end = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic finish_session();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("error_flag", 32'(error), 32'(m_err));
    chk("overflow_flag", 32'(overflow), 32'(m_ovf));
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
    chk("ready_after_done", 32'(in_ready), 32'd0);
  endtask

  initial begin
    int wcnt;
    int xcnt;
    int dcnt;
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; functcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0;
    imm = '0; target = '0;
    s_start = 1'b0; s_base = '0; s_valid = 1'b0; s_last = 1'b0;
    prev_we = 1'b0; m_addr = '0; m_err = 1'b0; m_ovf = 1'b0; sess_end = 1'b0;

    tbl[0]  = mk(6'h00, 6'h20,  1,  2,  3, 0, 16'h0000, 26'h0,       1, 32'h00221820);
    tbl[1]  = mk(6'h23, 6'h00, 29,  8,  0, 0, 16'h0004, 26'h0,       1, 32'h8FA80004);
    tbl[2]  = mk(6'h03, 6'h00,  0,  0,  0, 0, 16'h0000, 26'h0000010, 1, 32'h0C000010);
    tbl[3]  = mk(6'h00, 6'h08, 31,  7,  5, 3, 16'h0000, 26'h0,       1, 32'h03E00008);
    tbl[4]  = mk(6'h2b, 6'h00,  2,  3,  0, 0, 16'h0010, 26'h0,       1, 32'hAC430010);
    tbl[5]  = mk(6'h04, 6'h00,  1,  2,  0, 0, 16'hFFFF, 26'h0,       1, 32'h1022FFFF);
    tbl[6]  = mk(6'h08, 6'h00,  0,  5,  0, 0, 16'h7FFF, 26'h0,       1, 32'h20057FFF);
    tbl[7]  = mk(6'h02, 6'h00,  0,  0,  0, 0, 16'h0000, 26'h3FFFFFF, 1, 32'h0BFFFFFF);
    tbl[8]  = mk(6'h00, 6'h22,  4,  5,  6, 0, 16'h0000, 26'h0,       1, 32'h00853022);
    tbl[9]  = mk(6'h0e, 6'h00,  7,  9,  0, 0, 16'h00FF, 26'h0,       1, 32'h38E900FF);
    tbl[10] = mk(6'h0f, 6'h00,  1,  2,  3, 0, 16'h1234, 26'h0,       0, 32'h0);
    tbl[11] = mk(6'h00, 6'h21,  1,  2,  3, 0, 16'h0000, 26'h0,       0, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table: one instruction per session
    for (int i = 0; i < 12; i++) begin
      start_session(10'h010 + 10'(i * 2));
      xfer(tbl[i], 1'b1);
      finish_session();
    end

    // LW then JAL (last) at consecutive addresses
    start_session(10'h080);
    xfer(tbl[1], 1'b0);
    xfer(tbl[2], 1'b1);
    finish_session();

    // Unsupported opcode then SW at the unchanged address
    start_session(10'h040);
    xfer(tbl[10], 1'b0);
    chk("bad_op_error", 32'(error), 32'd1);
    chk("bad_op_addr_kept", 32'(im_addr), 32'h040);
    xfer(tbl[4], 1'b1);
    finish_session();

    // Idle gaps in LOAD, stray start ignored, then JR
    start_session(10'h020);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        base_addr = 10'h300;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk("ready_held", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    start = 1'b0;
    xfer(tbl[3], 1'b1);
    finish_session();

    // Reset during the WRITE cycle
    start_session(10'h100);
    xfer(tbl[11], 1'b0);
    xfer(tbl[0], 1'b0);
    chk("pre_reset_we", 32'(im_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_im_we", 32'(im_we), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_im_addr", 32'(im_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(in_ready), 32'd0);
    chk("abort_no_write", 32'(im_we), 32'd0);

    // Randomized sessions; the last one runs into the top address
    for (int s = 0; s < 10; s++) begin
      int n;
      logic [9:0] b;
      b = (s == 9) ? 10'h3FD : 10'($urandom_range(0, 10'h3C0));
      n = (s == 9) ? 5 : $urandom_range(1, 6);
      start_session(b);
      for (int i = 0; i < n; i++) begin
        vec_t v;
        if (sess_end) break;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        v = rand_instr();
        if (s == 9) v = tbl[0];
        xfer(v, (i == n - 1));
      end
      finish_session();
    end

    // ADDR_W=2 instance: five instructions offered from base 0
    set_fields(tbl[0]);
    s_base = 2'd0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    s_last = 1'b0;
    wcnt = 0; xcnt = 0; dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (s_we) begin
        chk("small_addr", 32'(s_addr), 32'(wcnt));
        chk("small_data", s_wdata, 32'h00221820);
        wcnt++;
      end
      if (s_ready && s_valid) xcnt++;
      if (s_done) dcnt++;
      if (xcnt == 5) s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("small_writes", 32'(wcnt), 32'd4);
    chk("small_accepted", 32'(xcnt), 32'd4);
    chk("small_done", 32'(dcnt), 32'd1);
    chk("small_overflow", 32'(s_ovf), 32'd1);
    chk("small_error", 32'(s_err), 32'd0);
    chk("small_idle", 32'(s_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
